// File: rtl/oam_scanner_pkg.sv
// Shared PPU definitions: mode encoding, OAM scan constants and the line-buffer entry type.
package ppu_pkg;

  typedef enum logic [1:0] {
    MODE_HBLANK  = 2'd0,
    MODE_VBLANK  = 2'd1,
    MODE_OAMSCAN = 2'd2,
    MODE_DRAW    = 2'd3
  } ppu_mode_e;

  localparam int OAM_ENTRIES      = 40;
  localparam int MAX_LINE_SPRITES = 10;
  localparam int OAM_SCAN_CYCLES  = 2 * OAM_ENTRIES;

  typedef struct packed {
    logic [7:0] x;
    logic [5:0] oam_idx;
  } sprite_entry_t;

endpackage

// File: rtl/oam_scanner_if.sv
// OAM read bus between the scanner (master) and the OAM array (slave).
interface oam_scanner_if;
  logic       oam_rd;
  logic [5:0] oam_idx;
  logic [7:0] oam_y;
  logic [7:0] oam_x;

  modport master (output oam_rd, output oam_idx, input oam_y, input oam_x);
  modport slave  (input oam_rd, input oam_idx, output oam_y, output oam_x);
endinterface

// File: rtl/oam_scanner_match.sv
// Vertical sprite/scanline coverage test; shared with the Draw stage for fine-row lookup.
module sprite_line_match (
  input  logic [7:0] ly,
  input  logic [7:0] y,
  input  logic       tall,
  output logic       hit
);

  logic [8:0] w_line;
  logic [8:0] w_top;
  logic [8:0] w_bottom;

  // Nine-bit sums so Y near 255 cannot wrap into a false hit.
  assign w_line   = {1'b0, ly} + 9'd16;
  assign w_top    = {1'b0, y};
  assign w_bottom = w_top + (tall ? 9'd16 : 9'd8);
  assign hit      = (w_line >= w_top) && (w_line < w_bottom);

endmodule

// File: rtl/oam_scanner.sv
// OAM scan stage: two cycles per entry, collects up to MAX_SPRITES covering sprites per line.
module oam_scanner
  import ppu_pkg::*;
#(
  parameter int NUM_OAM     = OAM_ENTRIES,
  parameter int MAX_SPRITES = MAX_LINE_SPRITES
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [7:0]         ly_in,
  input  logic               tall_in,
  oam_scanner_if.master      oam,
  output logic               busy_out,
  output logic               done_out,
  output logic [3:0]         count_out,
  input  logic [3:0]         rd_idx_in,
  output logic [7:0]         rd_x_out,
  output logic [5:0]         rd_oam_idx_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] MAX_CNT  = 4'(MAX_SPRITES);
  localparam logic [5:0] LAST_IDX = 6'(NUM_OAM - 1);

  logic [1:0]    r_state;
  logic [7:0]    r_ly;
  logic          r_tall;
  logic [5:0]    r_idx;
  logic          r_phase;
  logic [3:0]    r_count;
  logic          r_busy;
  logic          r_done;
  logic          r_oam_rd;
  sprite_entry_t r_slots [MAX_SPRITES];

  logic          w_hit;
  sprite_entry_t w_rd_entry;

  sprite_line_match u_match (
    .ly   (r_ly),
    .y    (oam.oam_y),
    .tall (r_tall),
    .hit  (w_hit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state  <= IDLE;
      r_ly     <= '0;
      r_tall   <= 1'b0;
      r_idx    <= '0;
      r_phase  <= 1'b0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_oam_rd <= 1'b0;
      // NOTE: the slot buffer is small flop storage, so clearing it in reset is cheap and keeps reads deterministic.
      for (int i = 0; i < MAX_SPRITES; i++) r_slots[i] <= '0;
    end else if (start_in) begin
      r_state  <= SCAN;
      r_ly     <= ly_in;
      r_tall   <= tall_in;
      r_idx    <= '0;
      r_phase  <= 1'b0;
      r_count  <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_oam_rd <= 1'b1;
    end else if (r_state == SCAN) begin
      if (!r_phase) begin
        r_phase  <= 1'b1;
        r_oam_rd <= 1'b0;
      end else begin
        // Overflowing hits are dropped without stopping, so the scan length never varies.
        if (w_hit && (r_count < MAX_CNT)) begin
          r_slots[r_count] <= '{x: oam.oam_x, oam_idx: r_idx};
          r_count          <= r_count + 4'd1;
        end
        r_phase <= 1'b0;
        if (r_idx == LAST_IDX) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_idx    <= r_idx + 6'd1;
          r_oam_rd <= 1'b1;
        end
      end
    end
  end

  // NOTE: w_rd_entry gets a default before the loop so this block can never infer a latch.
  always_comb begin
    w_rd_entry = '0;
    for (int i = 0; i < MAX_SPRITES; i++) begin
      if ((rd_idx_in == 4'(i)) && (4'(i) < r_count)) w_rd_entry = r_slots[i];
    end
  end

  assign oam.oam_rd     = r_oam_rd;
  assign oam.oam_idx    = r_idx;
  assign busy_out       = r_busy;
  assign done_out       = r_done;
  assign count_out      = r_count;
  assign rd_x_out       = w_rd_entry.x;
  assign rd_oam_idx_out = w_rd_entry.oam_idx;

endmodule

// File: tb/tb_oam_scanner.sv
// Directed bench for oam_scanner with a one-cycle-latency OAM array model.
module tb_oam_scanner;
  import ppu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] ly;
  logic       tall;
  logic [3:0] rd_idx;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic [7:0] rd_x;
  logic [5:0] rd_oidx;

  logic [7:0] mem_y [64];
  logic [7:0] mem_x [64];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  oam_scanner_if oam_bus ();

  oam_scanner dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .start_in       (start),
    .ly_in          (ly),
    .tall_in        (tall),
    .oam            (oam_bus),
    .busy_out       (busy),
    .done_out       (done),
    .count_out      (count),
    .rd_idx_in      (rd_idx),
    .rd_x_out       (rd_x),
    .rd_oam_idx_out (rd_oidx)
  );

  always @(posedge clk) begin
    if (oam_bus.oam_rd) begin
      oam_bus.oam_y <= mem_y[oam_bus.oam_idx];
      oam_bus.oam_x <= mem_x[oam_bus.oam_idx];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("%s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 64; i++) begin
      mem_y[i] = 8'd0;
      mem_x[i] = 8'd0;
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the start edge.
  task automatic pulse_start(input logic [7:0] l, input logic t);
    start = 1'b1;
    ly    = l;
    tall  = t;
    @(negedge clk);
    start = 1'b0;
    ly    = ~l;
    tall  = ~t;
    check("start_busy", busy, 1'b1);
    check("start_done_low", done, 1'b0);
    check("start_rd", oam_bus.oam_rd, 1'b1);
    check("start_idx", oam_bus.oam_idx, 6'd0);
  endtask

  task automatic wait_done_80();
    for (int i = 1; i < OAM_SCAN_CYCLES; i++) @(negedge clk);
    check("done_not_early", done, 1'b0);
    check("busy_before_end", busy, 1'b1);
    @(negedge clk);
    check("done_at_80", done, 1'b1);
    check("busy_after_end", busy, 1'b0);
  endtask

  task automatic run_scan(input logic [7:0] l, input logic t);
    pulse_start(l, t);
    wait_done_80();
  endtask

  task automatic read_slot(input string tag, input logic [3:0] slot,
                           input logic [7:0] exp_x, input logic [5:0] exp_idx);
    rd_idx = slot;
    @(negedge clk);
    check({tag, "_x"}, rd_x, exp_x);
    check({tag, "_idx"}, rd_oidx, exp_idx);
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b1;
    ly     = 8'd0;
    tall   = 1'b0;
    rd_idx = 4'd0;
    clear_oam();

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_rd", oam_bus.oam_rd, 1'b0);
    check("rst_idx", oam_bus.oam_idx, 6'd0);
    check("rst_slot_x", rd_x, 8'd0);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // Single 8-px hit: LY+16 = 16 lies in [16, 24).
    clear_oam();
    mem_y[5] = 8'd16;
    mem_x[5] = 8'd40;
    run_scan(8'd0, 1'b0);
    check("single_count", count, 4'd1);
    read_slot("single_s0", 4'd0, 8'd40, 6'd5);
    read_slot("single_s1", 4'd1, 8'd0, 6'd0);
    check("single_done_held", done, 1'b1);

    // LY=8 puts the line at 24: just past an 8-px sprite at Y=16, inside a 16-px one.
    clear_oam();
    mem_y[3] = 8'd16;
    mem_x[3] = 8'h33;
    run_scan(8'd8, 1'b0);
    check("short_miss_count", count, 4'd0);
    run_scan(8'd8, 1'b1);
    check("tall_hit_count", count, 4'd1);
    read_slot("tall_s0", 4'd0, 8'h33, 6'd3);
    clear_oam();
    mem_y[3] = 8'd25;
    run_scan(8'd8, 1'b1);
    check("above_miss_count", count, 4'd0);

    // Overflow: every entry covers line 26, only the first ten are kept.
    for (int i = 0; i < OAM_ENTRIES; i++) begin
      mem_y[i] = 8'd20;
      mem_x[i] = 8'(i + 100);
    end
    run_scan(8'd10, 1'b0);
    check("ovf_count", count, 4'd10);
    read_slot("ovf_s0", 4'd0, 8'd100, 6'd0);
    read_slot("ovf_s4", 4'd4, 8'd104, 6'd4);
    read_slot("ovf_s9", 4'd9, 8'd109, 6'd9);
    read_slot("ovf_s12", 4'd12, 8'd0, 6'd0);

    // X is irrelevant to selection; buffer keeps OAM order.
    clear_oam();
    mem_y[7] = 8'd16;
    mem_x[7] = 8'd0;
    mem_y[2] = 8'd16;
    mem_x[2] = 8'd200;
    run_scan(8'd0, 1'b0);
    check("xign_count", count, 4'd2);
    read_slot("xign_s0", 4'd0, 8'd200, 6'd2);
    read_slot("xign_s1", 4'd1, 8'd0, 6'd7);
    read_slot("xign_s2", 4'd2, 8'd0, 6'd0);

    // Restart 30 cycles in: entry 4 matched LY=0 but must vanish; entry 30 matches LY=100.
    clear_oam();
    mem_y[4]  = 8'd16;
    mem_x[4]  = 8'd11;
    mem_y[30] = 8'd116;
    mem_x[30] = 8'd77;
    pulse_start(8'd0, 1'b0);
    repeat (28) @(negedge clk);
    check("pre_restart_count", count, 4'd1);
    @(negedge clk);
    pulse_start(8'd100, 1'b0);
    check("restart_count_clr", count, 4'd0);
    wait_done_80();
    check("restart_count", count, 4'd1);
    read_slot("restart_s0", 4'd0, 8'd77, 6'd30);

    // Reset wins over a simultaneous start and clears the buffer.
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    check("rst_start_busy", busy, 1'b0);
    check("rst_start_count", count, 4'd0);
    read_slot("rst_clear_s0", 4'd0, 8'd0, 6'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
